// File: rtl/qtu_fmb_if.sv
// Packet, configuration and result bus of the QTU_FMB next-hop selector.
interface qtu_fmb_if;
  logic        en;
  logic        iAmDestination;
  logic        HB_Reset;
  logic [15:0] fSourceID;
  logic [15:0] fSourceHops;
  logic [15:0] fQValue;
  logic [15:0] fEnergyLeft;
  logic [15:0] fHopsFromCH;
  logic [15:0] fChosenCH;
  logic [15:0] chosenCH;
  logic [15:0] hopsFromCH;
  logic [15:0] myQValue;
  logic [15:0] nodeID;
  logic [15:0] nodeHops;
  logic [15:0] nodeEnergy;
  logic [15:0] nodeQValue;
  logic [4:0]  neighborIndex;
  logic [15:0] chosenHop;
  logic        QTUFMB_done;

  modport master (
    output en, iAmDestination, HB_Reset, fSourceID, fSourceHops, fQValue,
           fEnergyLeft, fHopsFromCH, fChosenCH, chosenCH, hopsFromCH, myQValue,
    input  nodeID, nodeHops, nodeEnergy, nodeQValue, neighborIndex, chosenHop,
           QTUFMB_done
  );

  modport slave (
    input  en, iAmDestination, HB_Reset, fSourceID, fSourceHops, fQValue,
           fEnergyLeft, fHopsFromCH, fChosenCH, chosenCH, hopsFromCH, myQValue,
    output nodeID, nodeHops, nodeEnergy, nodeQValue, neighborIndex, chosenHop,
           QTUFMB_done
  );
endinterface

// File: rtl/qtu_fmb.sv
// QTU_FMB: neighbor-table update and max-Q next-hop selection.
// Optional QTUFMB_ENERGY_TIEBREAK_EN: equal Q resolved by higher energy.
module qtu_fmb #(
  parameter int MAX_NEIGHBORS = 16
) (
  input  logic      clk,
  input  logic      nrst,
  qtu_fmb_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] SCAN  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [4:0] MAXN = 5'(MAX_NEIGHBORS);

`ifdef QTUFMB_ENERGY_TIEBREAK_EN
  localparam logic TIEBREAK = 1'b1;
`else
  localparam logic TIEBREAK = 1'b0;
`endif

  logic [2:0]  state_r;
  logic [15:0] tabId_r     [MAX_NEIGHBORS];
  logic [15:0] tabHops_r   [MAX_NEIGHBORS];
  logic [15:0] tabEnergy_r [MAX_NEIGHBORS];
  logic [15:0] tabQ_r      [MAX_NEIGHBORS];
  logic [4:0]  count_r;

  logic [15:0] pktId_r, pktHops_r, pktQ_r, pktEnergy_r, pktCh_r;
  logic        hit_r;
  logic [4:0]  slot_r;

  logic [4:0]  scanIdx_r;
  logic        bestValid_r;
  logic [15:0] bestQ_r, bestEnergy_r, bestId_r;

  logic [15:0] nodeId_r, nodeHops_r, nodeEnergy_r, nodeQ_r, chosenHop_r;
  logic [4:0]  neighborIndex_r;
  logic        done_r;

  logic        hit_s, accept_s;
  logic [4:0]  slot_s;
  logic [15:0] candId_s, candQ_s, candEnergy_s;
  logic        candValid_s, take_s, scanLast_s;
  logic        nextValid_s;
  logic [15:0] nextQ_s, nextEnergy_s, nextId_s;

  // Candidate (cq, ce) beats the running best unless Q is lower, or equal without an energy win.
  function automatic logic isBetter(input logic bestValid, input logic [15:0] bq,
                                    input logic [15:0] be, input logic [15:0] cq,
                                    input logic [15:0] ce);
    logic better;
    if (!bestValid) begin
      better = 1'b1;
    end else if (cq > bq) begin
      better = 1'b1;
    end else if (TIEBREAK && (cq == bq) && (ce > be)) begin
      better = 1'b1;
    end else begin
      better = 1'b0;
    end
    return better;
  endfunction

  // Parallel ID search over valid entries and packet acceptance test.
  always_comb begin
    hit_s  = 1'b0;
    slot_s = count_r;
    for (int i = MAX_NEIGHBORS - 1; i >= 0; i--) begin
      if ((5'(i) < count_r) && (tabId_r[i] == pktId_r)) begin
        hit_s  = 1'b1;
        slot_s = 5'(i);
      end else begin
        hit_s  = hit_s;
      end
    end
    accept_s = ((pktCh_r == bus.chosenCH) || (pktId_r == bus.chosenCH)) &&
               (pktId_r != 16'd0);
  end

  // Entry under the scan pointer and the running best after considering it.
  always_comb begin
    candId_s     = 16'd0;
    candQ_s      = 16'd0;
    candEnergy_s = 16'd0;
    for (int i = 0; i < MAX_NEIGHBORS; i++) begin
      if (5'(i) == scanIdx_r) begin
        candId_s     = tabId_r[i];
        candQ_s      = tabQ_r[i];
        candEnergy_s = tabEnergy_r[i];
      end else begin
        candId_s     = candId_s;
      end
    end
    candValid_s  = (scanIdx_r < count_r);
    take_s       = candValid_s &&
                   isBetter(bestValid_r, bestQ_r, bestEnergy_r, candQ_s, candEnergy_s);
    scanLast_s   = ((scanIdx_r + 5'd1) >= count_r);
    nextValid_s  = bestValid_r | take_s;
    if (take_s) begin
      nextQ_s      = candQ_s;
      nextEnergy_s = candEnergy_s;
      nextId_s     = candId_s;
    end else begin
      nextQ_s      = bestQ_r;
      nextEnergy_s = bestEnergy_r;
      nextId_s     = bestId_r;
    end
  end

  // Control FSM, neighbor table and registered outputs.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_r         <= IDLE;
      count_r         <= 5'd0;
      for (int i = 0; i < MAX_NEIGHBORS; i++) begin
        tabId_r[i]     <= 16'd0;
        tabHops_r[i]   <= 16'd0;
        tabEnergy_r[i] <= 16'd0;
        tabQ_r[i]      <= 16'd0;
      end
      pktId_r         <= 16'd0;
      pktHops_r       <= 16'd0;
      pktQ_r          <= 16'd0;
      pktEnergy_r     <= 16'd0;
      pktCh_r         <= 16'd0;
      hit_r           <= 1'b0;
      slot_r          <= 5'd0;
      scanIdx_r       <= 5'd0;
      bestValid_r     <= 1'b0;
      bestQ_r         <= 16'd0;
      bestEnergy_r    <= 16'd0;
      bestId_r        <= 16'd0;
      nodeId_r        <= 16'd0;
      nodeHops_r      <= 16'd0;
      nodeEnergy_r    <= 16'd0;
      nodeQ_r         <= 16'd0;
      neighborIndex_r <= 5'd0;
      chosenHop_r     <= 16'd0;
      done_r          <= 1'b0;
    end else if (bus.HB_Reset) begin
      // Heartbeat wins over everything, including a same-cycle en.
      state_r     <= IDLE;
      count_r     <= 5'd0;
      chosenHop_r <= 16'd0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.en) begin
            pktId_r     <= bus.fSourceID;
            pktHops_r   <= bus.fSourceHops;
            pktQ_r      <= bus.fQValue;
            pktEnergy_r <= bus.fEnergyLeft;
            pktCh_r     <= bus.fChosenCH;
            state_r     <= CHECK;
          end
        end
        CHECK: begin
          hit_r   <= hit_s;
          slot_r  <= slot_s;
          state_r <= accept_s ? WRITE : DONE;
        end
        WRITE: begin
          if (hit_r || (count_r < MAXN)) begin
            for (int i = 0; i < MAX_NEIGHBORS; i++) begin
              if (5'(i) == slot_r) begin
                tabId_r[i]     <= pktId_r;
                tabHops_r[i]   <= pktHops_r;
                tabEnergy_r[i] <= pktEnergy_r;
                tabQ_r[i]      <= pktQ_r;
              end
            end
            if (!hit_r) begin
              count_r <= count_r + 5'd1;
            end
            nodeId_r        <= pktId_r;
            nodeHops_r      <= pktHops_r;
            nodeEnergy_r    <= pktEnergy_r;
            nodeQ_r         <= pktQ_r;
            neighborIndex_r <= slot_r;
          end
          scanIdx_r   <= 5'd0;
          bestValid_r <= 1'b0;
          if (bus.iAmDestination) begin
            chosenHop_r <= bus.chosenCH;
            state_r     <= DONE;
          end else begin
            state_r     <= SCAN;
          end
        end
        SCAN: begin
          bestValid_r  <= nextValid_s;
          bestQ_r      <= nextQ_s;
          bestEnergy_r <= nextEnergy_s;
          bestId_r     <= nextId_s;
          if (scanLast_s) begin
            chosenHop_r <= (nextValid_s && (nextQ_s > bus.myQValue)) ? nextId_s : bus.chosenCH;
            state_r     <= DONE;
          end else begin
            scanIdx_r   <= scanIdx_r + 5'd1;
          end
        end
        DONE: begin
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.nodeID        = nodeId_r;
  assign bus.nodeHops      = nodeHops_r;
  assign bus.nodeEnergy    = nodeEnergy_r;
  assign bus.nodeQValue    = nodeQ_r;
  assign bus.neighborIndex = neighborIndex_r;
  assign bus.chosenHop     = chosenHop_r;
  assign bus.QTUFMB_done   = done_r;

endmodule

// File: tb/tb_qtu_fmb.sv
// Self-checking bench for qtu_fmb: directed vector table, corner sequences, random vs. model.
module tb_qtu_fmb;
  localparam int MAXN = 16;

  logic clk;
  logic nrst;
  qtu_fmb_if bus();

  qtu_fmb #(.MAX_NEIGHBORS(MAXN)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCnt = 0;
  int totalCnt = 0;

  // Reference model: plain table of neighbours plus last-written and selected values.
  int          mCount;
  logic [15:0] mId [MAXN];
  logic [15:0] mHops [MAXN];
  logic [15:0] mE [MAXN];
  logic [15:0] mQ [MAXN];
  logic [15:0] mNodeId, mNodeHops, mNodeE, mNodeQ, mHop;
  logic [4:0]  mIdx;

`ifdef QTUFMB_ENERGY_TIEBREAK_EN
  localparam bit TB_TIE = 1'b1;
`else
  localparam bit TB_TIE = 1'b0;
`endif

  typedef struct {
    logic [15:0] id, ch, q, e;
    logic        dest;
    logic [4:0]  expIdx;
    logic [15:0] expNodeId, expHop;
    int          expLat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
  endtask

  task automatic modelClear();
    mCount = 0; mNodeId = 16'd0; mNodeHops = 16'd0; mNodeE = 16'd0; mNodeQ = 16'd0;
    mHop = 16'd0; mIdx = 5'd0;
  endtask

  task automatic modelPkt(input logic [15:0] id, ch, q, e, hops, input logic dest,
                          output int expLat);
    int f, b;
    if (!((ch == bus.chosenCH || id == bus.chosenCH) && id != 16'd0)) begin
      expLat = 2;
    end else begin
      f = -1;
      for (int i = 0; i < mCount; i++) if (mId[i] == id) f = i;
      if (f < 0 && mCount < MAXN) begin
        f = mCount; mId[f] = id; mCount++;
      end
      if (f >= 0) begin
        mHops[f] = hops; mE[f] = e; mQ[f] = q;
        mNodeId = id; mNodeHops = hops; mNodeE = e; mNodeQ = q; mIdx = 5'(f);
      end
      if (dest) begin
        mHop = bus.chosenCH; expLat = 3;
      end else begin
        b = -1;
        for (int i = 0; i < mCount; i++)
          if (b < 0 || mQ[i] > mQ[b] || (TB_TIE && mQ[i] == mQ[b] && mE[i] > mE[b])) b = i;
        mHop = (b >= 0 && mQ[b] > bus.myQValue) ? mId[b] : bus.chosenCH;
        expLat = 3 + ((mCount > 0) ? mCount : 1);
      end
    end
  endtask

  task automatic checkOutputs(input string tag);
    chk({tag, " nodeID"}, 32'(bus.nodeID), 32'(mNodeId));
    chk({tag, " nodeHops"}, 32'(bus.nodeHops), 32'(mNodeHops));
    chk({tag, " nodeEnergy"}, 32'(bus.nodeEnergy), 32'(mNodeE));
    chk({tag, " nodeQValue"}, 32'(bus.nodeQValue), 32'(mNodeQ));
    chk({tag, " neighborIndex"}, 32'(bus.neighborIndex), 32'(mIdx));
    chk({tag, " chosenHop"}, 32'(bus.chosenHop), 32'(mHop));
  endtask

  task automatic runPkt(input logic [15:0] id, ch, q, e, hops, input logic dest,
                        input string tag, output int lat);
    int expLat;
    @(negedge clk);
    bus.fSourceID = id; bus.fChosenCH = ch; bus.fQValue = q; bus.fEnergyLeft = e;
    bus.fSourceHops = hops; bus.fHopsFromCH = hops + 16'd1; bus.iAmDestination = dest;
    bus.en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (bus.QTUFMB_done) begin lat = c; break; end
    end
    modelPkt(id, ch, q, e, hops, dest, expLat);
    chk({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutputs(tag);
    @(posedge clk); #1;
    chk({tag, " done width"}, 32'(bus.QTUFMB_done), 32'd0);
  endtask

  task automatic hbPulse(input logic withEn);
    @(negedge clk);
    bus.HB_Reset = 1'b1; bus.en = withEn;
    @(posedge clk);
    @(negedge clk);
    bus.HB_Reset = 1'b0; bus.en = 1'b0;
    mCount = 0; mHop = 16'd0;
  endtask

  task automatic watchNoDone(input string tag, input int cycles);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (bus.QTUFMB_done) seen++;
    end
    chk({tag, " no done"}, 32'(seen), 32'd0);
  endtask

  vec_t vecs[6];
  int   lat;

  initial begin
    nrst = 1'b1;
    bus.en = 1'b0; bus.iAmDestination = 1'b0; bus.HB_Reset = 1'b0;
    bus.fSourceID = 16'd0; bus.fSourceHops = 16'd0; bus.fQValue = 16'd0;
    bus.fEnergyLeft = 16'd0; bus.fHopsFromCH = 16'd0; bus.fChosenCH = 16'd0;
    bus.chosenCH = 16'd5; bus.hopsFromCH = 16'd2; bus.myQValue = 16'h4000;
    modelClear();
    repeat (3) @(posedge clk);
    #1;
    checkOutputs("reset");
    chk("reset done", 32'(bus.QTUFMB_done), 32'd0);
    @(negedge clk) nrst = 1'b0;

    hbPulse(1'b0);
    watchNoDone("hb idle", 5);
    checkOutputs("hb idle");

    // Directed vectors with chosenCH=5, myQValue=0x4000.
    vecs[0] = '{16'd3, 16'd5, 16'h6000, 16'h0100, 1'b0, 5'd0, 16'd3, 16'd3, 4};
    vecs[1] = '{16'd3, 16'd5, 16'h3000, 16'h0100, 1'b0, 5'd0, 16'd3, 16'd5, 4};
    vecs[2] = '{16'd7, 16'd9, 16'h7000, 16'h0100, 1'b0, 5'd0, 16'd3, 16'd5, 2};
    vecs[3] = '{16'd8, 16'd5, 16'h5000, 16'h0200, 1'b1, 5'd1, 16'd8, 16'd5, 3};
    vecs[4] = '{16'd5, 16'd0, 16'h4800, 16'h0300, 1'b0, 5'd2, 16'd5, 16'd8, 6};
    vecs[5] = '{16'd0, 16'd5, 16'hF000, 16'h0300, 1'b0, 5'd2, 16'd5, 16'd8, 2};
    for (int v = 0; v < 6; v++) begin
      runPkt(vecs[v].id, vecs[v].ch, vecs[v].q, vecs[v].e, 16'd1, vecs[v].dest,
             $sformatf("vec%0d", v), lat);
      chk($sformatf("vec%0d exp latency", v), 32'(lat), 32'(vecs[v].expLat));
      chk($sformatf("vec%0d exp index", v), 32'(bus.neighborIndex), 32'(vecs[v].expIdx));
      chk($sformatf("vec%0d exp nodeID", v), 32'(bus.nodeID), 32'(vecs[v].expNodeId));
      chk($sformatf("vec%0d exp chosenHop", v), 32'(bus.chosenHop), 32'(vecs[v].expHop));
    end

    // Full table: 103 and 107 share the maximum Q; 107 has more energy.
    hbPulse(1'b0);
    for (int i = 0; i < MAXN; i++) begin
      runPkt(16'(100 + i), 16'd5, (i == 3 || i == 7) ? 16'h7FFF : 16'(16'h1000 + i),
             (i == 7) ? 16'h0900 : 16'h0100, 16'(i), 1'b0, $sformatf("fill%0d", i), lat);
    end
    runPkt(16'd200, 16'd5, 16'hFFFF, 16'hFFFF, 16'd9, 1'b0, "drop", lat);
    chk("drop exp latency", 32'(lat), 32'(3 + MAXN));
    chk("drop exp index", 32'(bus.neighborIndex), 32'(MAXN - 1));
    chk("drop exp nodeID", 32'(bus.nodeID), 32'(100 + MAXN - 1));
    chk("drop exp chosenHop", 32'(bus.chosenHop), TB_TIE ? 32'd107 : 32'd103);

    // HB_Reset in mid-SCAN, together with en: aborts without done.
    @(negedge clk);
    bus.fSourceID = 16'd50; bus.fChosenCH = 16'd5; bus.fQValue = 16'h1234;
    bus.fEnergyLeft = 16'h0011; bus.fSourceHops = 16'd4; bus.iAmDestination = 1'b0;
    bus.en = 1'b1;
    @(posedge clk);
    @(negedge clk) bus.en = 1'b0;
    watchNoDone("midop pre-hb", 3);
    modelPkt(16'd50, 16'd5, 16'h1234, 16'h0011, 16'd4, 1'b0, lat);
    hbPulse(1'b1);
    watchNoDone("midop hb", 25);
    checkOutputs("midop hb");
    runPkt(16'd60, 16'd5, 16'h2000, 16'h0001, 16'd2, 1'b0, "after hb", lat);

    // Asynchronous reset in the middle of a packet.
    @(negedge clk);
    bus.fSourceID = 16'd61; bus.en = 1'b1;
    @(posedge clk);
    @(negedge clk) bus.en = 1'b0;
    @(negedge clk) nrst = 1'b1;
    #1;
    modelClear();
    checkOutputs("async rst");
    @(negedge clk) nrst = 1'b0;
    watchNoDone("async rst", 8);
    runPkt(16'd62, 16'd5, 16'h5000, 16'h0001, 16'd3, 1'b0, "after rst", lat);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        hbPulse($urandom_range(0, 1) == 1);
        watchNoDone("rand hb", 2);
        chk("rand hb chosenHop", 32'(bus.chosenHop), 32'd0);
      end else begin
        bus.myQValue = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7) << 13);
        runPkt(($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 22)),
               ($urandom_range(0, 3) != 0) ? 16'd5 : 16'($urandom_range(0, 15)),
               16'($urandom_range(0, 7) << 13), 16'($urandom_range(0, 3)),
               16'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
               $sformatf("rand%0d", n), lat);
      end
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/qtu_fmb.md
QTU_FMB -- requirements
Module: qtu_fmb

Interface
REQ-001 Parameter MAX_NEIGHBORS, default 16, neighbor-table capacity (legal 1..31).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 nrst  in  1  asynchronous reset; asserted when high.
REQ-005 en  in  1  one-cycle strobe: received-packet fields f* are valid.
REQ-006 iAmDestination  in  1  node is the cluster head/sink; no next-hop search.
REQ-007 HB_Reset  in  1  heartbeat strobe; clears the neighbor table.
REQ-008 fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH  in  16 each  packet sender ID, hops, Q value, energy, hops to its CH, its CH.
REQ-009 chosenCH, hopsFromCH, myQValue  in  16 each  own CH ID, own hops to CH, own Q value (unsigned).
REQ-010 nodeID, nodeHops, nodeEnergy, nodeQValue  out  16 each  contents of the table entry last written.
REQ-011 neighborIndex  out  5  index of the table entry last written.
REQ-012 chosenHop  out  16  selected next-hop ID.
REQ-013 QTUFMB_done  out  1  one-cycle completion pulse.

Function
REQ-014 Table SHALL hold MAX_NEIGHBORS entries {ID, hops, energy, Q} plus a count (0..MAX_NEIGHBORS); valid entries occupy indices 0..count-1.
REQ-015 FSM states: IDLE, CHECK, WRITE, SCAN, DONE; en SHALL be ignored outside IDLE.
REQ-016 IDLE: on en=1, register all f* inputs and go to CHECK.
REQ-017 CHECK (1 cycle): accept if fChosenCH==chosenCH or fSourceID==chosenCH, and fSourceID!=0; reject -> DONE with table and outputs unchanged.
REQ-018 CHECK: search all valid entries in parallel for ID==fSourceID; a hit selects that index, a miss selects index=count.
REQ-019 WRITE (1 cycle): hit -> overwrite hops, energy, Q; miss with count<MAX_NEIGHBORS -> append and count+1; miss with table full -> drop packet, no write.
REQ-020 Each write SHALL update nodeID/nodeHops/nodeEnergy/nodeQValue/neighborIndex to the written entry; a dropped packet leaves them unchanged.
REQ-021 SCAN: one entry per cycle, index 0..count-1; best = entry with largest Q, ties keep the lower index. With count=0, SCAN lasts 1 cycle.
REQ-022 End of SCAN: chosenHop = best ID if best Q > myQValue (unsigned), else chosenHop = chosenCH.
REQ-023 With iAmDestination=1 the table is still updated, SCAN is skipped and chosenHop = chosenCH.
REQ-024 DONE: QTUFMB_done=1 for exactly one cycle, then IDLE.
REQ-025 Latency from the en edge to QTUFMB_done high: accepted packet 3+max(count,1) cycles (count after write), where count = number of valid table entries; rejected packet 2 cycles; iAmDestination 3 cycles.
REQ-026 HB_Reset=1 in any state SHALL, on the next edge, set count=0, chosenHop=0 and state IDLE without a done pulse. HB_Reset has priority over a simultaneous en, and that en is discarded.

Reset
REQ-027 nrst high SHALL immediately force IDLE, count=0, all table entries 0, all outputs 0 (QTUFMB_done=0).
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse; the first en after release is processed normally.

Configuration
REQ-029 Macro QTUFMB_ENERGY_TIEBREAK_EN defined: on equal Q during SCAN, the entry with higher energy wins, and a further tie keeps the lower index. Undefined: equal Q keeps the lower index (REQ-021).

Verification
REQ-030 Reset, then HB_Reset pulse -> all outputs 0, count 0, no QTUFMB_done.
REQ-031 chosenCH=5, myQValue=0x4000; en with ID=3, CH=5, Q=0x6000, E=0x0100 -> neighborIndex=0, nodeID=3, chosenHop=3, done 4 cycles after en.
REQ-032 Then en with ID=3, Q=0x3000 -> same index 0 updated, count stays 1, chosenHop=5 (0x3000<=0x4000).
REQ-033 Packet with fChosenCH=9 (chosenCH=5) -> done after 2 cycles, outputs unchanged.
REQ-034 Fill MAX_NEIGHBORS distinct IDs, then send a new ID -> dropped, count stays MAX_NEIGHBORS, chosenHop = max-Q ID.
REQ-035 iAmDestination=1 with a valid packet -> entry written, chosenHop=chosenCH, done after 3 cycles.
